// File: rtl/four_one_tdm_pkg.sv
// Shared types and defaults for the 4:1 time-division multiplexer.
// Imported by the arbiter and the top level.
package four_one_tdm_pkg;

  localparam int NCH           = 4;
  localparam int W_DEF         = 8;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/four_one_tdm_mux_rr_arbiter4.sv
// Combinational round-robin pick: first requester at or after ptr, scanning
// upward modulo 4.
module rr_arbiter4
  import four_one_tdm_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant_idx,
  output logic       any
);

  logic [1:0] idx;

  // Walk from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    grant_idx = ptr;
    idx       = '0;
    any       = |req;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) grant_idx = idx;
    end
  end

endmodule

// File: rtl/four_one_tdm_mux.sv
// Four-channel to one serializer: round-robin grants with a burst cap and a
// single output register that sustains one beat per cycle.
module four_one_tdm_mux
  import four_one_tdm_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     in_valid,
  input  logic [4*W-1:0] in_data,
  output logic [3:0]     in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [1:0]     Sel,
  input  logic           out_ready
);

  localparam logic [3:0] MB = 4'(MAX_BURST);

  state_e         state_q;
  logic [1:0]     g_q;
  logic [1:0]     ptr_q;
  logic [3:0]     cnt_q;
  logic           out_valid_q;
  logic [W-1:0]   out_data_q;
  logic [1:0]     sel_q;

  logic [1:0]     arb_idx;
  logic           arb_any;
  logic           can_load;
  logic           xfer;
  logic [3:0]     cnt_d;
  logic [1:0]     ptr_d;

  rr_arbiter4 u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign can_load = !out_valid_q || out_ready;
  assign cnt_d    = cnt_q + 4'd1;
  assign ptr_d    = g_q + 2'd1;

  // in_ready is masked during reset so no beat is offered while state is discarded.
  always_comb begin
    in_ready = 4'b0000;
    if (!rst && state_q == GRANT && can_load) in_ready[g_q] = 1'b1;
  end

  assign xfer = in_valid[g_q] && in_ready[g_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            state_q <= GRANT;
            g_q     <= arb_idx;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (!in_valid[g_q]) begin
            state_q <= IDLE;
            ptr_q   <= ptr_d;
          end else if (xfer) begin
            cnt_q <= cnt_d;
            if (cnt_d == MB) begin
              state_q <= IDLE;
              ptr_q   <= ptr_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output register: a load takes priority over a drain, giving no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_q       <= 2'b00;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in_data[g_q*W +: W];
      sel_q       <= g_q;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign Sel       = sel_q;

endmodule

// File: tb/tb_four_one_tdm_mux.sv
// Bench for four_one_tdm_mux: directed table, corner sequences and random
// traffic against a channel-level reference model (two burst limits).
module tb_four_one_tdm_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic [3:0]  ir0, ir1;
  logic        ov0, ov1;
  logic [7:0]  od0, od1;
  logic [1:0]  sel0, sel1;

  always #5 clk = ~clk;

  four_one_tdm_mux #(.W(8), .MAX_BURST(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir0), .out_valid(ov0), .out_data(od0), .Sel(sel0),
    .out_ready(out_ready)
  );

  four_one_tdm_mux #(.W(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1), .Sel(sel1),
    .out_ready(out_ready)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: per instance, who owns the link, beats sent, next start.
  int m_busy[2], m_own[2], m_cnt[2], m_ptr[2], m_ov[2], m_od[2], m_os[2];
  int mb[2];

  logic [7:0] sbq[$];
  logic [7:0] acc_d0[$];
  logic [1:0] acc_sel1[$];
  int         acc_cyc[$];
  bit         last_x0;
  int         last_own0;

  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic [31:0] d;
    logic        ordy;
    logic        eov;
    logic [1:0]  esel;
    logic [7:0]  eod;
    logic [3:0]  eir;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] m_rdy(int k);
    logic [3:0] r;
    r = 4'b0000;
    if (!rst && m_busy[k] != 0 && (m_ov[k] == 0 || out_ready)) r[m_own[k]] = 1'b1;
    return r;
  endfunction

  task automatic m_update(int k);
    logic [3:0] r;
    bit x, found;
    r = m_rdy(k);
    x = (m_busy[k] != 0) && in_valid[m_own[k]] && r[m_own[k]];
    if (rst) begin
      m_busy[k] = 0; m_own[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
      m_ov[k] = 0; m_od[k] = 0; m_os[k] = 0;
      return;
    end
    if (x) begin
      m_ov[k] = 1; m_od[k] = int'(in_data[m_own[k]*8 +: 8]); m_os[k] = m_own[k];
    end else if (out_ready) begin
      m_ov[k] = 0;
    end
    if (m_busy[k] == 0) begin
      found = 0;
      for (int j = 0; j < 4; j++) begin
        int c;
        c = (m_ptr[k] + j) % 4;
        if (in_valid[c] && !found) begin
          m_own[k] = c; found = 1;
        end
      end
      if (found) begin
        m_busy[k] = 1; m_cnt[k] = 0;
      end
    end else if (!in_valid[m_own[k]]) begin
      m_busy[k] = 0; m_ptr[k] = (m_own[k] + 1) % 4;
    end else if (x) begin
      m_cnt[k]++;
      if (m_cnt[k] == mb[k]) begin
        m_busy[k] = 0; m_ptr[k] = (m_own[k] + 1) % 4;
      end
    end
  endtask

  // Called at the falling edge: compare, score, then advance one clock.
  task automatic tail();
    logic [3:0] r0;
    chk("ov0",  ov0,  m_ov[0]); chk("sel0", sel0, m_os[0]);
    chk("od0",  od0,  m_od[0]); chk("ir0",  ir0,  m_rdy(0));
    chk("ov1",  ov1,  m_ov[1]); chk("sel1", sel1, m_os[1]);
    chk("od1",  od1,  m_od[1]); chk("ir1",  ir1,  m_rdy(1));
    if (ov0 && out_ready && !rst) begin
      if (sbq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL sb_extra: got beat %0h expected none", od0);
      end else begin
        chk("sb_data", od0, sbq.pop_front());
      end
      acc_d0.push_back(od0);
      acc_cyc.push_back(cyc);
    end
    if (ov1 && out_ready && !rst) acc_sel1.push_back(sel1);
    r0 = m_rdy(0);
    last_own0 = m_own[0];
    last_x0 = !rst && (m_busy[0] != 0) && in_valid[m_own[0]] && r0[m_own[0]];
    if (last_x0) sbq.push_back(in_data[m_own[0]*8 +: 8]);
    @(posedge clk);
    m_update(0);
    m_update(1);
    if (rst) sbq.delete();
    cyc++;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    tail();
  endtask

  task automatic clear_logs();
    acc_d0.delete(); acc_sel1.delete(); acc_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    int prev1, b2b, xc;
    mb[0] = 4; mb[1] = 1;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_own[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
      m_ov[k] = 0; m_od[k] = 0; m_os[k] = 0;
    end

    tbl[0] = '{1'b1, 4'b1111, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000};
    tbl[1] = '{1'b1, 4'b1111, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000};
    tbl[2] = '{1'b0, 4'b0100, 32'h00A5_0000, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000};
    tbl[3] = '{1'b0, 4'b0100, 32'h00A5_0000, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0100};
    tbl[4] = '{1'b0, 4'b0000, 32'h00A5_0000, 1'b1, 1'b1, 2'd2, 8'hA5, 4'b0100};
    tbl[5] = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd2, 8'hA5, 4'b0000};
    tbl[6] = '{1'b1, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd2, 8'hA5, 4'b0000};
    tbl[7] = '{1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000};

    // Bring both instances out of power-up before anything is compared.
    rst = 1'b1; in_valid = 4'b0000; in_data = '0; out_ready = 1'b1;
    @(posedge clk);
    m_update(0); m_update(1);
    #1;

    for (int i = 0; i < 8; i++) begin
      rst = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d_ov", i),  ov0,  tbl[i].eov);
      chk($sformatf("tbl%0d_sel", i), sel0, tbl[i].esel);
      chk($sformatf("tbl%0d_od", i),  od0,  tbl[i].eod);
      chk($sformatf("tbl%0d_ir", i),  ir0,  tbl[i].eir);
      tail();
    end

    // Round robin with a one-beat burst limit.
    do_reset();
    in_valid = 4'b1111; in_data = 32'h0302_0100; out_ready = 1'b1;
    prev1 = 0; b2b = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (prev1 != 0 && ov1) b2b++;
      prev1 = ov1;
    end
    chk("rr_count", acc_sel1.size() >= 5, 1);
    if (acc_sel1.size() >= 5) begin
      chk("rr_sel0", acc_sel1[0], 0); chk("rr_sel1", acc_sel1[1], 1);
      chk("rr_sel2", acc_sel1[2], 2); chk("rr_sel3", acc_sel1[3], 3);
      chk("rr_sel4", acc_sel1[4], 0);
    end
    chk("rr_gap", b2b, 0);

    // Burst cap on channel 3 with incrementing data.
    do_reset();
    in_valid = 4'b1000; in_data = 32'h1000_0000; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (last_x0 && last_own0 == 3) in_data[31:24] = in_data[31:24] + 8'd1;
    end
    chk("burst_count", acc_d0.size() >= 6, 1);
    if (acc_d0.size() >= 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("burst_d%0d", i), acc_d0[i], 32'h10 + i);
      chk("burst_run", acc_cyc[3] - acc_cyc[0], 3);
      chk("burst_gap", acc_cyc[4] - acc_cyc[3], 2);
    end

    // Backpressure on the first beat of channel 0.
    do_reset();
    in_valid = 4'b0001; in_data = 32'h0000_003C; out_ready = 1'b1;
    for (int i = 0; i < 10 && !ov0; i++) begin
      step();
      if (last_x0) in_data[7:0] = in_data[7:0] + 8'd1;
    end
    chk("bp_first", ov0, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_d", od0, 8'h3C);
      chk("bp_hold_s", sel0, 2'd0);
      chk("bp_hold_r", ir0, 4'b0000);
      tail();
      if (last_x0) in_data[7:0] = in_data[7:0] + 8'd1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (last_x0) in_data[7:0] = in_data[7:0] + 8'd1;
    end
    chk("bp_count", acc_d0.size() >= 3, 1);
    if (acc_d0.size() >= 3) begin
      chk("bp_b0", acc_d0[0], 8'h3C); chk("bp_b1", acc_d0[1], 8'h3D);
      chk("bp_b2", acc_d0[2], 8'h3E);
    end

    // Reset in the middle of a channel 1 burst.
    do_reset();
    in_valid = 4'b0010; in_data = 32'h0000_5000; out_ready = 1'b1;
    xc = 0;
    for (int i = 0; i < 10 && xc < 2; i++) begin
      step();
      if (last_x0) begin
        xc++; in_data[15:8] = in_data[15:8] + 8'd1;
      end
    end
    chk("mbr_beats", xc, 2);
    rst = 1'b1; in_valid = 4'b1111;
    step();
    chk("mbr_ov", ov0, 0);
    rst = 1'b0;
    for (int i = 0; i < 10 && !ov0; i++) step();
    chk("mbr_found", ov0, 1);
    chk("mbr_sel", sel0, 2'd0);

    // Random traffic, occasional reset.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
